// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: stage indices,
// FSM state encoding and the stall vector patterns driven onto the pipeline.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;
  localparam int unsigned STALL_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  // Each pattern stalls the named stage and everything upstream of it.
  localparam logic [STALL_W-1:0] STALL_NONE   = 5'b00000;
  localparam logic [STALL_W-1:0] STALL_TO_IF  = 5'b00001;
  localparam logic [STALL_W-1:0] STALL_TO_ID  = 5'b00011;
  localparam logic [STALL_W-1:0] STALL_TO_EX  = 5'b00111;
  localparam logic [STALL_W-1:0] STALL_TO_MEM = 5'b01111;
  localparam logic [STALL_W-1:0] STALL_ALL    = 5'b11111;

endpackage

// File: rtl/pipe_hazard_ctrl_stall_watchdog.sv
// Saturating consecutive-stall counter; raises a sticky error flag once the
// pipeline has been held for STALL_TIMEOUT cycles in a row.
module stall_watchdog #(
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned WDT_W         = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic stall_timeout
);

  localparam logic [WDT_W-1:0] LIMIT = WDT_W'(STALL_TIMEOUT);

  logic [WDT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q | (cnt_q == LIMIT);
    if (!stalled) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Define
// PIPE_PERF_CNT_EN to build the stall-cycle and flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned WDT_W         = 11,
  parameter int unsigned ADDR_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stall_req,
  input  logic               id_stall_req,
  input  logic               ex_stall_req,
  input  logic               mem_stall_req,
  input  logic               flush_req,
  input  logic [ADDR_W-1:0]  flush_target,
  input  logic               if_bus_busy,
  input  logic               mem_bus_busy,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [ADDR_W-1:0]  flush_pc,
  output logic               stall_timeout,
  output logic [31:0]        perf_stall_cycles,
  output logic [15:0]        perf_flush_count
);

  hz_state_e         state_q, state_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] flush_pc_q, flush_pc_d;
  logic              bus_busy;

  assign bus_busy = if_bus_busy | mem_bus_busy;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    flush_pc_d = flush_pc_q;
    stall      = STALL_NONE;
    unique case (state_q)
      RUN: begin
        if (flush_req) begin
          // Hold IF..MEM so the excepting instruction bubbles out of WB.
          stall    = STALL_TO_MEM;
          target_d = flush_target;
          state_d  = bus_busy ? DRAIN : FLUSH;
        end else if (mem_stall_req) begin
          stall = STALL_TO_MEM;
        end else if (ex_stall_req) begin
          stall = STALL_TO_EX;
        end else if (id_stall_req) begin
          stall = STALL_TO_ID;
        end else if (if_stall_req) begin
          stall = STALL_TO_IF;
        end
      end
      DRAIN: begin
        stall = STALL_ALL;
        if (!bus_busy) state_d = FLUSH;
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
    flush_d = (state_d == FLUSH);
    if (state_d == FLUSH) flush_pc_d = target_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      target_q   <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT),
    .WDT_W        (WDT_W)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stalled      (stall != STALL_NONE),
    .stall_timeout(stall_timeout)
  );

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + ((stall != STALL_NONE) ? 32'd1 : 32'd0);
    perf_flush_d = perf_flush_q + (flush_q ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_count  = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipeline (IF, ID, EX, MEM, WB). Collects per-stage stall requests and the MEM-stage exception/flush request. Drives the per-stage stall vector that feeds every inter-stage register's stall_current_stage/stall_next_stage pair. Defers flushes until outstanding bus transactions drain, and watches for hung stalls.

Parameters:
STALL_TIMEOUT, 1024, consecutive stalled cycles before stall_timeout is raised
WDT_W, 11, watchdog counter width; must satisfy 2^WDT_W > STALL_TIMEOUT
ADDR_W, 32, flush target PC width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
if_stall_req  in  1  IF needs to hold (fetch miss)
id_stall_req  in  1  ID load-use hazard
ex_stall_req  in  1  EX multicycle op busy
mem_stall_req  in  1  MEM data bus not ready
flush_req  in  1  MEM-stage exception/eret; valid for one cycle
flush_target  in  ADDR_W  handler/return PC, qualified by flush_req
if_bus_busy  in  1  instruction bus transaction outstanding
mem_bus_busy  in  1  data bus transaction outstanding
stall  out  5  bit0=IF, bit1=ID, bit2=EX, bit3=MEM, bit4=WB; IDEX uses stall[1] as current and stall[2] as next
flush  out  1  one-cycle squash of all inter-stage registers
flush_pc  out  ADDR_W  PC to load into IF, valid when flush=1
stall_timeout  out  1  sticky watchdog error
perf_stall_cycles  out  32  cycles with stall!=0 (optional feature)
perf_flush_count  out  16  flushes issued (optional feature)

Behaviour:
- Reset: state=RUN, stall=0, flush=0, flush_pc=0, stall_timeout=0, watchdog=0, perf counters=0.
- FSM states: RUN, DRAIN, FLUSH. State, flush and flush_pc are registered. stall is combinational from state and inputs.
- RUN stall encoding, highest stage wins:
  - mem_stall_req -> 01111
  - else ex_stall_req -> 00111
  - else id_stall_req -> 00011
  - else if_stall_req -> 00001
  - else 00000
  - stall[4] is never set in RUN. A stalled stage with an unstalled successor inserts a bubble.
- RUN and flush_req=1:
  - Latch flush_target.
  - stall=01111 this cycle, overriding all requests, so the excepting instruction is bubbled out of WB.
  - If if_bus_busy|mem_bus_busy, go to DRAIN; else go to FLUSH.
- DRAIN:
  - stall=11111.
  - flush_req is ignored; the first latched target wins.
  - When both busy inputs are low, go to FLUSH.
- FLUSH:
  - flush=1 and flush_pc=latched target, for exactly one cycle.
  - stall=00000; stall requests and flush_req are ignored.
  - Next state is RUN.
- Latency: flush_req to flush is 1 cycle with the bus idle, otherwise 1 + drain cycles.
- Back-to-back: flush_req in the cycle after FLUSH is accepted normally in RUN.
- Watchdog:
  - Increments every cycle stall!=0 and clears on any cycle stall==0.
  - Saturates at STALL_TIMEOUT.
  - stall_timeout is set in the cycle after the count reaches STALL_TIMEOUT and stays set until rst.
- Reset mid-DRAIN or mid-FLUSH returns to RUN with flush=0. No pending flush survives.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined:
  - perf_stall_cycles increments on each cycle with stall!=0 and wraps at 2^32.
  - perf_flush_count increments on each cycle with flush=1 and wraps at 2^16.
  - Both clear on rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package holds:
  - stage index constants (STG_IF=0 … STG_WB=4) and STALL_W=5
  - FSM state encoding (RUN=2'd0, DRAIN=2'd1, FLUSH=2'd2)
  - stall vector constants STALL_NONE, STALL_TO_IF, STALL_TO_ID, STALL_TO_EX, STALL_TO_MEM, STALL_ALL
- One sub-module, stall_watchdog: saturating consecutive-stall counter with sticky flag, parameterised by STALL_TIMEOUT and WDT_W.

Test Plan:
- ex_stall_req=1 for 3 cycles, others 0 -> stall=00111 for those 3 cycles, then 00000; flush stays 0.
- mem_stall_req=1 and id_stall_req=1 together -> stall=01111.
- flush_req=1, flush_target=0xBFC00380, busy=0 -> that cycle stall=01111; next cycle flush=1, flush_pc=0xBFC00380, stall=00000; following cycle flush=0.
- flush_req with mem_bus_busy=1 for 4 more cycles, plus a second flush_req during DRAIN with target 0x80000000 -> stall=11111 during DRAIN; flush=1 with flush_pc=first target exactly one cycle after busy drops.
- if_stall_req held, STALL_TIMEOUT=8 -> stall_timeout rises after 8 stalled cycles and stays 1 after the request drops; clears only on rst.
- rst asserted in DRAIN -> next cycle state=RUN, flush=0, stall=00000; with PIPE_PERF_CNT_EN, counters read 0.
